// File: rtl/banco_registradores_param.sv
// banco_registradores_param
// Operand register file for the datapath: two bypassed read ports (RS/RT),
// one non-bypassed read port (RD) addressed by the write address, one write
// port, and a 2*LARGURA HI/LO accumulator supporting load/add/subtract.
// After reset a clear engine zeroes entries 1..NUM_REGS-1, one per cycle,
// so the array itself carries no reset and can map onto RAM.
module banco_registradores_param #(
  parameter  int LARGURA  = 32,
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [AW-1:0]          endereco_leitura1,
  input  logic [AW-1:0]          endereco_leitura2,
  input  logic [AW-1:0]          endereco_escrita,
  input  logic                   writeRegs,
  input  logic [LARGURA-1:0]     dados_escrita,
  input  logic [1:0]             modo_hilo,
  input  logic [2*LARGURA-1:0]   dados_hilo,
  output logic [LARGURA-1:0]     leituraRS,
  output logic [LARGURA-1:0]     leituraRT,
  output logic [LARGURA-1:0]     leituraRD,
  output logic [LARGURA-1:0]     hi,
  output logic [LARGURA-1:0]     lo,
  output logic                   ocupado
);

  // FSM encoding
  localparam logic [0:0] LIMPANDO = 1'b0;
  localparam logic [0:0] PRONTO   = 1'b1;

  // HI/LO operation codes
  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_LOAD = 2'b01;
  localparam logic [1:0] HL_ACC  = 2'b10;
  localparam logic [1:0] HL_SUB  = 2'b11;

  localparam logic [AW-1:0] ULTIMO = AW'(NUM_REGS - 1);

  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [2*LARGURA-1:0] hilo_q, hilo_d;
  logic [LARGURA-1:0]   regs_q [NUM_REGS];

  logic pronto;
  logic wr_en;

  assign pronto  = (state_q == PRONTO);
  assign ocupado = ~pronto;

  // A write only lands once the sweep is over and never on register 0.
  assign wr_en = writeRegs && pronto && (endereco_escrita != '0);

  // Clear sweep sequencing: walk 1..NUM_REGS-1, leave LIMPANDO on the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == LIMPANDO) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == ULTIMO) state_d = PRONTO;
    end
  end

  // HI/LO next value; arithmetic wraps modulo 2^(2*LARGURA), carry crosses lo->hi.
  always_comb begin
    hilo_d = hilo_q;
    if (pronto) begin
      case (modo_hilo)
        HL_LOAD: hilo_d = dados_hilo;
        HL_ACC:  hilo_d = hilo_q + dados_hilo;
        HL_SUB:  hilo_d = hilo_q - dados_hilo;
        default: hilo_d = hilo_q;
      endcase
    end
  end

  // Control state and accumulator: asynchronous clear back into the sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LIMPANDO;
      cnt_q   <= AW'(1);
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hilo_q  <= hilo_d;
    end
  end

  // Storage array, deliberately without reset: the sweep zeroes it instead.
  // Entry 0 is never written; every read path masks it to zero.
  always_ff @(posedge clock) begin
    if (!pronto) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[endereco_escrita] <= dados_escrita;
    end
  end

  // RS port: forced to zero during the sweep, write-through bypass otherwise.
  always_comb begin
    leituraRS = '0;
    if (pronto && (endereco_leitura1 != '0)) begin
      if (wr_en && (endereco_leitura1 == endereco_escrita)) leituraRS = dados_escrita;
      else                                                  leituraRS = regs_q[endereco_leitura1];
    end
  end

  // RT port: same rules as RS on the second read address.
  always_comb begin
    leituraRT = '0;
    if (pronto && (endereco_leitura2 != '0)) begin
      if (wr_en && (endereco_leitura2 == endereco_escrita)) leituraRT = dados_escrita;
      else                                                  leituraRT = regs_q[endereco_leitura2];
    end
  end

  // RD port: stored (pre-write) value at the write address, never bypassed.
  always_comb begin
    leituraRD = '0;
    if (pronto && (endereco_escrita != '0)) leituraRD = regs_q[endereco_escrita];
  end

  // Accumulator halves are presented straight from the register.
  assign hi = hilo_q[2*LARGURA-1:LARGURA];
  assign lo = hilo_q[LARGURA-1:0];

endmodule
